// File: rtl/fw_loader.sv
// Firmware loader: receives a length-prefixed, checksummed byte stream and writes
// 32-bit words into a ROM, holding the core in reset until a load completes cleanly.
module fw_loader #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  core_rst_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] Capacity = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLen, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            csum_q, csum_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;

  logic        rx_state, accept, timeout, last_word, arm, oversize;
  logic [31:0] len_full;

  assign rx_state  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept    = rx_valid_i && rx_state;
  // Timeout wins over a byte arriving in the same cycle.
  assign timeout   = rx_state && (tmo_q >= TmoW'(TIMEOUT_CYCLES - 1));
  assign len_full  = {rx_data_i, len_q[23:0]};
  assign oversize  = {1'b0, len_full} > Capacity;
  assign last_word = ({1'b0, addr_q} + (ADDR_WIDTH + 1)'(1)) == len_q[ADDR_WIDTH:0];
  assign arm       = start_i && ((state_q == StIdle) || (state_q == StDone) ||
                                 (state_q == StErr));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) state_d = StLen;
      end
      StLen: begin
        if (timeout) begin
          state_d = StErr;
        end else if (accept && (bcnt_q == 2'd3)) begin
          if (len_full == 32'd0)  state_d = StCsum;
          else if (oversize)      state_d = StErr;
          else                    state_d = StData;
        end
      end
      StData: begin
        if (timeout)                              state_d = StErr;
        else if (accept && (bcnt_q == 2'd3))      state_d = StWrite;
      end
      StWrite: begin
        state_d = last_word ? StCsum : StData;
      end
      StCsum: begin
        if (timeout)      state_d = StErr;
        else if (accept)  state_d = (rx_data_i == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    if (arm) begin
      bcnt_d = '0;
      len_d  = '0;
      addr_d = '0;
      csum_d = '0;
      tmo_d  = '0;
    end else if (rx_state) begin
      if (accept) begin
        tmo_d  = '0;
        bcnt_d = bcnt_q + 2'd1;
        if (state_q == StLen) begin
          len_d[8*bcnt_q +: 8] = rx_data_i;
        end else if (state_q == StData) begin
          wdata_d[8*bcnt_q +: 8] = rx_data_i;
          csum_d                 = csum_q + rx_data_i;
        end
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end else if (state_q == StWrite) begin
      // Only a full-capacity load reaches the top address; hold it there.
      if (!(&addr_q)) addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    rx_ready_o  = rx_state;
    mem_we_o    = (state_q == StWrite);
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    busy_o      = rx_state || (state_q == StWrite);
    done_o      = (state_q == StDone);
    err_o       = (state_q == StErr);
    core_rst_o  = (state_q != StDone);
  end

endmodule
